seven_seg_scan_mux: RTL and testbench
=====================================

// Module: seven_seg_scan_mux
// PURPOSE
//   Downstream of the per-digit 7-segment decoders. Takes DIGITS decoded segment patterns
//   and time-multiplexes them onto one shared segment bus with per-digit anode drive.
//   Each digit slot starts with a blanking interval to suppress ghosting.
//   Drives the board display pins directly. All outputs are registered.
// PARAMETERS
//   DIGITS        4      number of multiplexed digits (2..8)
//   PRESCALE      50000  clk cycles per digit slot (1 kHz/digit at 50 MHz); >= 4
//   BLANK_CYCLES  500    cycles at start of each slot with all anodes off; 1 <= BLANK_CYCLES < PRESCALE
// PORTS
//   clk           in   1          system clock, rising edge
//   reset         in   1          reset, synchronous, active-high
//   seg_in        in   7*DIGITS   decoded patterns, active-low; digit k at [7k+6:7k], bit order gfedcba
//   dp_in         in   DIGITS     decimal points, active-low, bit k = digit k
//   digit_en      in   DIGITS     1 = digit k shown; 0 = anode held off for its slot
//   seg           out  7          segment bus, active-low
//   dp            out  1          decimal point, active-low
//   an            out  DIGITS     anode selects, active-low, one-hot-low or all-high
//   frame_strobe  out  1          1-cycle pulse when the digit index wraps DIGITS-1 -> 0
// BEHAVIOUR
//   - Reset (sync, checked every cycle, overrides everything): seg=7'h7F, dp=1, an=all 1s,
//     frame_strobe=0, slot counter=0, digit index=0, state=BLANK. Asserting reset
//     mid-slot blanks the outputs on the next edge and restarts at digit 0.
//   - Slot counter cnt runs 0..PRESCALE-1. Width is $clog2(PRESCALE). It wraps to 0 and
//     advances the digit index modulo DIGITS.
//   - FSM, two states:
//       BLANK: an=all 1s, seg=7'h7F, dp=1. Active while cnt < BLANK_CYCLES.
//         On the edge where cnt reaches BLANK_CYCLES, go to SHOW. On the same edge,
//         latch seg_in/dp_in/digit_en for the current index.
//       SHOW: seg and dp come from the latched values. an[idx]=0 only if the latched
//         digit_en=1; otherwise an stays all 1s and seg=7'h7F.
//         At cnt=PRESCALE-1, go to BLANK and set idx=idx+1 (or 0 on wrap).
//   - Inputs are sampled once per slot. Changes during SHOW appear in the next slot of
//     that digit, never mid-slot.
//   - Disabled digits still use their full slot time, so brightness of enabled digits
//     does not depend on digit_en.
//   - frame_strobe=1 for exactly one cycle: the edge where idx goes DIGITS-1 -> 0.
//     Its period is DIGITS*PRESCALE cycles.
//   - Output timing, counted from reset deassertion (first edge with reset=0 = cycle 0):
//     an[0] first goes low at cycle BLANK_CYCLES+1 (registered outputs).
//     Per slot, anode on-time = PRESCALE-BLANK_CYCLES cycles.
//   - Outputs never select more than one anode in any cycle, including across the
//     BLANK/SHOW transitions.
// STRUCTURE
//   - Shared package seven_seg_pkg holds:
//       SEG_OFF = 7'h7F, AN_OFF,
//       the state encoding ST_BLANK = 1'b0, ST_SHOW = 1'b1,
//       the gfedcba bit-order constants (shared with the decoder blocks).
//   - One sub-module, scan_tick_gen. It holds the PRESCALE counter and emits:
//       blank_end pulse at cnt == BLANK_CYCLES-1,
//       slot_end pulse at cnt == PRESCALE-1.
//     The top level holds the FSM, digit index, input latch and output registers.
// TESTING  (bench params: DIGITS=4, PRESCALE=8, BLANK_CYCLES=2)
//   1. Reset hold 3 cycles, then release.
//      -> During reset: seg=7F, an=4'b1111, dp=1.
//      -> an=4'b1110 from cycle 3 to cycle 8, then 1111 for 2 cycles, then 4'b1101.
//   2. seg_in = {7'h30,7'h24,7'h79,7'h40}, dp_in=4'b1110, digit_en=4'hF.
//      -> Observed sequence: (an=1110, seg=40, dp=0), (1101, 79, 1), (1011, 24, 1),
//         (0111, 30, 1), repeating.
//      -> frame_strobe pulses every 32 cycles.
//   3. digit_en=4'b1011.
//      -> Digit 2 slot keeps an=1111 and seg=7F for all 8 cycles.
//      -> Other digits keep 6-cycle on-time; frame period stays 32.
//   4. Change seg_in[6:0] from 7'h40 to 7'h79 mid-SHOW of digit 0.
//      -> seg stays 40 until the slot ends.
//      -> 79 appears at the next digit-0 SHOW.
//   5. Assert reset for 1 cycle during digit 2 SHOW.
//      -> Next edge: an=1111, seg=7F.
//      -> Restart: digit 0 is shown after 2 blank cycles; no frame_strobe is emitted
//         for the aborted frame.
//   6. Every cycle across a 200-cycle run with random seg_in/digit_en:
//      -> Assert that at most one an bit is low.
//      -> Assert that seg=7F whenever an=1111.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment display path: blank patterns, scan FSM
// state encoding and gfedcba segment bit positions.
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    // Widest anode bus supported (8 digits); users slice the low DIGITS bits.
    localparam logic [7:0] AN_OFF  = 8'hFF;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

endpackage

// File: rtl/seven_seg_scan_mux_scan_tick_gen.sv
// Per-slot timebase: free-running PRESCALE counter with registered one-cycle
// pulses marking the end of the blanking interval and the end of the slot.
module scan_tick_gen #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic reset,
    output logic blank_end,
    output logic slot_end
);

    localparam int CNT_W = $clog2(PRESCALE);

    logic [CNT_W-1:0] cnt;

    // Pulses are registered, so each is high the cycle after cnt hits its match value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            blank_end <= 1'b0;
            slot_end  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            cnt       <= (cnt == CNT_W'(PRESCALE - 1)) ? '0 : cnt + CNT_W'(1);
            blank_end <= (cnt == CNT_W'(BLANK_CYCLES - 1));
            slot_end  <= (cnt == CNT_W'(PRESCALE - 1));
        end
    end

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexes DIGITS decoded segment patterns onto one shared segment bus
// with per-digit active-low anodes and a blanking interval at the start of each slot.
module seven_seg_scan_mux
    import seven_seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7*DIGITS-1:0]   seg_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_strobe
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [DIGITS-1:0] AN_ALL_OFF = AN_OFF[DIGITS-1:0];

    logic              blank_end;
    logic              slot_end;
    scan_state_t       state;
    logic [IDX_W-1:0]  idx;
    logic [6:0]        lat_seg;
    logic              lat_dp;
    logic              lat_en;

    scan_tick_gen #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_BLANK;
            idx          <= '0;
            lat_seg      <= SEG_OFF;
            lat_dp       <= 1'b1;
            lat_en       <= 1'b0;
            seg          <= SEG_OFF;
            dp           <= 1'b1;
            an           <= AN_ALL_OFF;
            frame_strobe <= 1'b0;
        end else begin
            // Outputs follow the pre-edge state, so idx never changes while an anode is on.
            if (state == ST_SHOW && lat_en) begin
                seg <= lat_seg;
                dp  <= lat_dp;
                an  <= ~(DIGITS'(1) << idx);
            end else begin
                seg <= SEG_OFF;
                dp  <= 1'b1;
                an  <= AN_ALL_OFF;
            end
            frame_strobe <= 1'b0;

            case (state)
                ST_BLANK: begin
                    if (blank_end) begin
                        state   <= ST_SHOW;
                        lat_seg <= seg_in[7*idx +: 7];
                        lat_dp  <= dp_in[idx];
                        lat_en  <= digit_en[idx];
                    end
                end
                ST_SHOW: begin
                    if (slot_end) begin
                        state <= ST_BLANK;
                        if (idx == IDX_W'(DIGITS - 1)) begin
                            idx          <= '0;
                            frame_strobe <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= ST_BLANK;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Self-checking bench for seven_seg_scan_mux: directed scenarios plus random
// traffic, compared every cycle against a slot-timeline reference model.
module tb_seven_seg_scan_mux;

    localparam int D = 4;
    localparam int P = 8;
    localparam int B = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [7*D-1:0] seg_in;
    logic [D-1:0]   dp_in;
    logic [D-1:0]   digit_en;
    logic [6:0]     seg;
    logic           dp;
    logic [D-1:0]   an;
    logic           frame_strobe;

    seven_seg_scan_mux #(
        .DIGITS       (D),
        .PRESCALE     (P),
        .BLANK_CYCLES (B)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .seg_in       (seg_in),
        .dp_in        (dp_in),
        .digit_en     (digit_en),
        .seg          (seg),
        .dp           (dp),
        .an           (an),
        .frame_strobe (frame_strobe)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int tests = 0;
    int fails = 0;
    int k = -1;            // edges since reset release; -1 while in reset
    int cyc = 0;
    int strobes = 0;
    int last_strobe = -1;

    logic [6:0]   snap_seg = 7'h7F;
    logic         snap_dp = 1'b1;
    logic         snap_en = 1'b0;
    logic [D-1:0] exp_an;
    logic [6:0]   exp_seg;
    logic         exp_dp;
    logic         exp_fs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s (k=%0d): observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // One clock: advance the reference timeline, then sample and compare #1 after the edge.
    task automatic step();
        int t, d, pos;
        @(posedge clk);
        cyc++;
        if (reset) begin
            k = -1;
            last_strobe = -1;
        end else begin
            k++;
            if (k >= B && (k - B) % P == 0) begin
                d = ((k - B) / P) % D;
                snap_seg = seg_in[7*d +: 7];
                snap_dp  = dp_in[d];
                snap_en  = digit_en[d];
            end
        end
        exp_an = '1; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
        if (k >= B + 1) begin
            t   = k - B - 1;
            pos = t % P;
            d   = (t / P) % D;
            if (pos < P - B && snap_en) begin
                exp_an  = ~(D'(1) << d);
                exp_seg = snap_seg;
                exp_dp  = snap_dp;
            end
        end
        if (k > 0 && k % (D * P) == 0) exp_fs = 1'b1;
        #1;
        check("an", an, exp_an);
        check("seg", seg, exp_seg);
        check("dp", dp, exp_dp);
        check("frame_strobe", frame_strobe, exp_fs);
        check("an_onehot", ($countones(~an) <= 1), 1);
        check("blank_seg", (an != '1) || (seg == 7'h7F), 1);
        if (frame_strobe) begin
            if (last_strobe >= 0) check("strobe_period", cyc - last_strobe, D * P);
            last_strobe = cyc;
            strobes++;
        end
    endtask

    task automatic wait_an(input logic [D-1:0] target, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            step();
            if (an === target) found = 1'b1;
        end
        check(tag, found, 1);
    endtask

    initial begin
        logic [D-1:0] an_tbl [12];
        logic [D-1:0] an_show [4];
        logic [6:0]   seg_show [4];
        logic         dp_show [4];
        int on_cnt [4];
        int strobes_at_reset;

        an_tbl   = '{4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD};
        an_show  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_show = '{7'h40, 7'h79, 7'h24, 7'h30};
        dp_show  = '{1'b0, 1'b1, 1'b1, 1'b1};

        seg_in   = {7'h30, 7'h24, 7'h79, 7'h40};
        dp_in    = 4'b1110;
        digit_en = 4'hF;

        // 1: reset hold and first-slot timing
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_reset_an", an, 4'hF);
            check("t1_reset_seg", seg, 7'h7F);
        end
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("t1_an_k%0d", k), an, an_tbl[i]);
        end

        // 2: full scan sequence and frame strobe
        while (k < 72) begin
            step();
            if (k % P == B + 1) begin
                check("t2_an", an, an_show[(k / P) % D]);
                check("t2_seg", seg, seg_show[(k / P) % D]);
                check("t2_dp", dp, dp_show[(k / P) % D]);
            end
        end
        check("t2_strobe_count", strobes, 2);

        // 3: disabled digit keeps its slot; others keep full on-time
        digit_en = 4'b1011;
        for (int i = 0; i < 24; i++) step();
        on_cnt = '{0, 0, 0, 0};
        for (int i = 0; i < D * P; i++) begin
            step();
            for (int j = 0; j < D; j++) if (an == ~(D'(1) << j)) on_cnt[j]++;
        end
        for (int j = 0; j < D; j++) check($sformatf("t3_on_d%0d", j), on_cnt[j], (j == 2) ? 0 : P - B);
        digit_en = 4'hF;

        // 4: input change mid-SHOW is deferred to the next slot of that digit
        for (int i = 0; i < D * P; i++) step();
        wait_an(4'b1110, "t4_find_d0");
        step();
        seg_in[6:0] = 7'h79;
        step();
        check("t4_hold", seg, 7'h40);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_hold_rest", seg, 7'h40);
        end
        wait_an(4'b1110, "t4_find_d0_next");
        check("t4_new", seg, 7'h79);

        // 5: reset mid-SHOW of digit 2
        wait_an(4'b1011, "t5_find_d2");
        step();
        reset = 1'b1;
        step();
        check("t5_an_off", an, 4'hF);
        check("t5_seg_off", seg, 7'h7F);
        reset = 1'b0;
        strobes_at_reset = strobes;
        for (int i = 0; i < 31; i++) begin
            step();
            if (k == B + 1) check("t5_restart_an", an, 4'b1110);
        end
        check("t5_no_strobe", strobes, strobes_at_reset);
        step();
        step();
        check("t5_strobe_after_frame", strobes, strobes_at_reset + 1);

        // 6: random traffic, model and invariants every cycle
        for (int i = 0; i < 200; i++) begin
            seg_in   = {$urandom, $urandom};
            dp_in    = D'($urandom);
            digit_en = D'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
